veri_datapath: RTL and testbench
================================

VERI_DATAPATH -- requirements
Module: veri_datapath

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 mode  in  1  ALU operation group: 0 arithmetic/logic, 1 shift/misc.
REQ-005 ALUSrcA  in  1  SrcA select: 0 RD1, 1 PC.
REQ-006 ALUSrcB  in  2  SrcB select: 00 RD2, 01 imm, 10 constant 1, 11 constant 0.
REQ-007 ALU_control  in  3  operation within the selected group.
REQ-008 ResultSrc  in  2  result select: 00 ALU_out, 01 DR_out, 10 combinational ALU result, 11 imm.
REQ-009 MemWrite, RegWrite, PCWrite  in  1 each  write enables for data memory, register file and PC.
REQ-010 A1, A2, A3  in  3 each  register-file read port 1, read port 2 and write addresses.
REQ-011 imm  in  8  immediate operand.
REQ-012 ALU_out, DR_out, PC  out  8 each  registered ALU result, data register and program counter.
REQ-013 memory_out, RD1, RD2, result, SrcA, SrcB  out  8 each  combinational data-memory read, register reads, result mux and ALU operands.

Function
REQ-014 All arithmetic SHALL be 8-bit, modulo 256; carries and overflows are discarded, and PC wraps from 0xFF to 0x00.
REQ-015 mode=0 operations: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 B, 111 A.
REQ-016 mode=1 operations: 000 A<<1, 001 logical A>>1, 010 arithmetic A>>1, 011 rotate A left by 1, 100 rotate A right by 1, 101 A+1, 110 A-1, 111 0x00.
REQ-017 ALU_out SHALL load the combinational ALU result on every rising edge.
REQ-018 The register file SHALL be 8x8 with asynchronous reads (RD1=reg[A1], RD2=reg[A2]) and a synchronous write of result to reg[A3] when RegWrite=1.
REQ-019 Data memory SHALL be 256x8: address=ALU_out, asynchronous read to memory_out, synchronous write of RD2 when MemWrite=1.
REQ-020 DR_out SHALL load memory_out on every rising edge.
REQ-021 PC SHALL load result on a rising edge when PCWrite=1, and otherwise hold.
REQ-022 A read of an address written in the same cycle SHALL return the old value until the edge and the new value after it; this applies to both the register file and memory.
REQ-023 All enables MAY be asserted together; each write SHALL use the pre-edge values of result, ALU_out and RD2.
REQ-024 No output SHALL depend combinationally on a clock edge.

Reset
REQ-025 While rst_n=0: PC, ALU_out, DR_out and all eight registers SHALL clear to 0x00 immediately, and writes SHALL be blocked.
REQ-026 Memory contents SHALL be unaffected by reset and SHALL be 0x00 at time zero.
REQ-027 Reset asserted mid-instruction SHALL abort the instruction; there is no pending state.

Configuration
REQ-028 With VERI_DATAPATH_R0_ZERO_EN defined, register 0 SHALL always read 0x00 and ignore writes.
REQ-029 Without VERI_DATAPATH_R0_ZERO_EN, register 0 SHALL be an ordinary register.

Structure
REQ-030 Package veri_datapath_pkg SHALL hold the width constants, the ALUSrcB and ResultSrc encodings, and the ALU opcode constants for both modes.
REQ-031 The ALU SHALL be a sub-module named veri_alu (inputs A, B, mode, ALU_control; output 8-bit result); all other logic stays in veri_datapath.

Verification
REQ-032 Reset: after rst_n low then high, PC=ALU_out=DR_out=0x00, and RD1=RD2=0x00 for every address.
REQ-033 Fetch: PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10 for 3 edges -> PC=0x03; starting from PC=0xFF, one edge -> PC=0x00.
REQ-034 Data processing: load R1=0x05 and R3=0x03 (A1=0, ALUSrcB=01, ResultSrc=10, RegWrite); then A1=1, A2=3, mode=0, ALU_control=001 -> ALU_out=0x02; then ResultSrc=00, RegWrite=1, A3=2 -> R2 reads 0x02.
REQ-035 Store then load:
- A1=1, imm=0x04, ALUSrcB=01, ADD -> ALU_out=0x09;
- MemWrite=1 with A2=3 -> mem[9]=0x03;
- next edge -> DR_out=0x03;
- ResultSrc=01, RegWrite=1, A3=4 -> R4=0x03.
REQ-036 Shift group: reg value 0x81, mode=1; ALU_control=011 -> 0x03, 010 -> 0xC0, 001 -> 0x40.
REQ-037 Reset mid-operation: rst_n low between edges during PCWrite -> PC=0x00 without waiting for an edge; separately, with VERI_DATAPATH_R0_ZERO_EN defined, writing 0x55 to R0 -> RD1=0x00.

Source files
------------

// File: rtl/veri_datapath_pkg.sv
// Shared widths, mux encodings and ALU opcodes for the veri_datapath slice.
package veri_datapath_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_AW    = 3;
  localparam int NUM_REGS  = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_ONE  = 2'b10,
    SRCB_ZERO = 2'b11
  } srcb_sel_e;

  typedef enum logic [1:0] {
    RES_ALU_OUT = 2'b00,
    RES_DR_OUT  = 2'b01,
    RES_ALU     = 2'b10,
    RES_IMM     = 2'b11
  } result_sel_e;

  // mode = 0: arithmetic / logic group
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_PASB = 3'b110;
  localparam logic [2:0] OP_PASA = 3'b111;

  // mode = 1: shift / misc group
  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_ASR  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;
  localparam logic [2:0] OP_DEC  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

endpackage

// File: rtl/veri_datapath_alu.sv
// veri_alu: purely combinational 8-bit ALU with two operation groups selected by mode.
module veri_alu
  import veri_datapath_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              mode,
  input  logic [2:0]        ALU_control,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    if (!mode) begin
      case (ALU_control)
        OP_ADD:  result = A + B;
        OP_SUB:  result = A - B;
        OP_AND:  result = A & B;
        OP_OR:   result = A | B;
        OP_XOR:  result = A ^ B;
        OP_NOT:  result = ~A;
        OP_PASB: result = B;
        default: result = A;
      endcase
    end else begin
      case (ALU_control)
        OP_SHL:  result = {A[DATA_W-2:0], 1'b0};
        OP_SHR:  result = {1'b0, A[DATA_W-1:1]};
        OP_ASR:  result = {A[DATA_W-1], A[DATA_W-1:1]};
        OP_ROL:  result = {A[DATA_W-2:0], A[DATA_W-1]};
        OP_ROR:  result = {A[0], A[DATA_W-1:1]};
        OP_INC:  result = A + 8'd1;
        OP_DEC:  result = A - 8'd1;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/veri_datapath.sv
// veri_datapath: 8-bit datapath with register file, data memory, PC, ALU_out and DR_out registers.
// Optional feature: define VERI_DATAPATH_R0_ZERO_EN to hardwire register 0 to 0x00.
module veri_datapath
  import veri_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              ALUSrcA,
  input  logic [1:0]        ALUSrcB,
  input  logic [2:0]        ALU_control,
  input  logic [1:0]        ResultSrc,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              PCWrite,
  input  logic [REG_AW-1:0] A1,
  input  logic [REG_AW-1:0] A2,
  input  logic [REG_AW-1:0] A3,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] ALU_out,
  output logic [DATA_W-1:0] DR_out,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] memory_out,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] SrcA,
  output logic [DATA_W-1:0] SrcB
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  // Memory is never reset; it only starts out cleared.
  logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: '0};
  logic [DATA_W-1:0] alu_result;

`ifdef VERI_DATAPATH_R0_ZERO_EN
  assign RD1 = (A1 == '0) ? '0 : regs[A1];
  assign RD2 = (A2 == '0) ? '0 : regs[A2];
`else
  assign RD1 = regs[A1];
  assign RD2 = regs[A2];
`endif

  assign memory_out = mem[ALU_out];
  assign SrcA       = ALUSrcA ? PC : RD1;

  always_comb begin
    SrcB = '0;
    case (ALUSrcB)
      SRCB_RD2: SrcB = RD2;
      SRCB_IMM: SrcB = imm;
      SRCB_ONE: SrcB = 8'd1;
      default:  SrcB = '0;
    endcase
  end

  veri_alu u_alu (
    .A           (SrcA),
    .B           (SrcB),
    .mode        (mode),
    .ALU_control (ALU_control),
    .result      (alu_result)
  );

  always_comb begin
    result = '0;
    case (ResultSrc)
      RES_ALU_OUT: result = ALU_out;
      RES_DR_OUT:  result = DR_out;
      RES_ALU:     result = alu_result;
      default:     result = imm;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC      <= '0;
      ALU_out <= '0;
      DR_out  <= '0;
    end else begin
      ALU_out <= alu_result;
      DR_out  <= memory_out;
      if (PCWrite) PC <= result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
`ifdef VERI_DATAPATH_R0_ZERO_EN
      if (RegWrite && (A3 != '0)) regs[A3] <= result;
`else
      if (RegWrite) regs[A3] <= result;
`endif
    end
  end

  // rst_n gates the write so a reset held across an edge cannot disturb memory.
  always_ff @(posedge clk) begin
    if (MemWrite && rst_n) mem[ALU_out] <= RD2;
  end

endmodule

// File: tb/tb_veri_datapath.sv
// Self-checking bench for veri_datapath: directed scenarios plus randomized cycles against a behavioural model.
module tb_veri_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode, ALUSrcA, MemWrite, RegWrite, PCWrite;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [2:0] ALU_control, A1, A2, A3;
  logic [7:0] imm;
  logic [7:0] ALU_out, DR_out, PC, memory_out, RD1, RD2, result, SrcA, SrcB;

  int n_checks = 0;
  int n_fails  = 0;

  int m_regs [8];
  int m_mem  [256];
  int m_pc, m_alu_out, m_dr;

  veri_datapath dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALU_control(ALU_control), .ResultSrc(ResultSrc), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .PCWrite(PCWrite), .A1(A1), .A2(A2), .A3(A3), .imm(imm),
    .ALU_out(ALU_out), .DR_out(DR_out), .PC(PC), .memory_out(memory_out),
    .RD1(RD1), .RD2(RD2), .result(result), .SrcA(SrcA), .SrcB(SrcB)
  );

  always #5 clk = ~clk;

  // Behavioural model: the ALU is described with plain integer arithmetic.
  function automatic int model_rd(int a);
`ifdef VERI_DATAPATH_R0_ZERO_EN
    if (a == 0) return 0;
`endif
    return m_regs[a];
  endfunction

  function automatic int alu_ref(int md, int op, int a, int b);
    if (md == 0) begin
      case (op)
        0: return (a + b) % 256;
        1: return (a - b + 256) % 256;
        2: return a & b;
        3: return a | b;
        4: return a ^ b;
        5: return 255 - a;
        6: return b;
        default: return a;
      endcase
    end
    case (op)
      0: return (a * 2) % 256;
      1: return a / 2;
      2: return a / 2 + ((a >= 128) ? 128 : 0);
      3: return (a * 2) % 256 + a / 128;
      4: return a / 2 + (a % 2) * 128;
      5: return (a + 1) % 256;
      6: return (a + 255) % 256;
      default: return 0;
    endcase
  endfunction

  function automatic int m_srca();
    return ALUSrcA ? m_pc : model_rd(int'(A1));
  endfunction

  function automatic int m_srcb();
    case (ALUSrcB)
      2'd0: return model_rd(int'(A2));
      2'd1: return int'(imm);
      2'd2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int m_alu();
    return alu_ref(int'(mode), int'(ALU_control), m_srca(), m_srcb());
  endfunction

  function automatic int m_result();
    case (ResultSrc)
      2'd0: return m_alu_out;
      2'd1: return m_dr;
      2'd2: return m_alu();
      default: return int'(imm);
    endcase
  endfunction

  // One rising edge: snapshot pre-edge values, advance the model, return to the falling edge.
  task automatic cycle();
    int res, alu, wd, mo;
    res = m_result();
    alu = m_alu();
    wd  = model_rd(int'(A2));
    mo  = m_mem[m_alu_out];
    @(posedge clk);
    if (RegWrite) m_regs[A3] = res;
    if (MemWrite) m_mem[m_alu_out] = wd;
    if (PCWrite) m_pc = res;
    m_alu_out = alu;
    m_dr      = mo;
    @(negedge clk);
  endtask

  task automatic idle();
    mode = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALU_control = 3'b000;
    ResultSrc = 2'b00; MemWrite = 1'b0; RegWrite = 1'b0; PCWrite = 1'b0;
    A1 = 3'd0; A2 = 3'd0; A3 = 3'd0; imm = 8'h00;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_pc = 0; m_alu_out = 0; m_dr = 0;
  endtask

  task automatic load_reg(input logic [2:0] r, input logic [7:0] v);
    ALUSrcA = 1'b0; A1 = 3'd0; ALUSrcB = 2'b01; imm = v; mode = 1'b0;
    ALU_control = 3'b000; ResultSrc = 2'b11; RegWrite = 1'b1; A3 = r;
    cycle();
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    reset_model();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (PC !== 8'h00 || ALU_out !== 8'h00 || DR_out !== 8'h00) begin
      n_fails++;
      $display("[TB] FAIL reset_regs: PC=%h ALU_out=%h DR_out=%h, expected 00/00/00", PC, ALU_out, DR_out);
    end
    n_checks++;
    if (memory_out !== 8'h00) begin
      n_fails++;
      $display("[TB] FAIL reset_mem0: memory_out=%h, expected 00", memory_out);
    end
    for (int i = 0; i < 8; i++) begin
      A1 = 3'(i); A2 = 3'(i);
      #1;
      n_checks++;
      if (RD1 !== 8'h00 || RD2 !== 8'h00) begin
        n_fails++;
        $display("[TB] FAIL reset_rf[%0d]: RD1=%h RD2=%h, expected 00", i, RD1, RD2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fetch();
    idle();
    PCWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    repeat (3) cycle();
    n_checks++;
    if (PC !== 8'h03) begin
      n_fails++;
      $display("[TB] FAIL fetch_3: PC=%h, expected 03", PC);
    end
    ResultSrc = 2'b11; imm = 8'hFF;
    cycle();
    ResultSrc = 2'b10;
    cycle();
    n_checks++;
    if (PC !== 8'h00) begin
      n_fails++;
      $display("[TB] FAIL fetch_wrap: PC=%h, expected 00", PC);
    end
    idle();
  endtask

  task automatic test_data_proc();
    idle();
    load_reg(3'd1, 8'h05);
    load_reg(3'd3, 8'h03);
    ALUSrcA = 1'b0; ALUSrcB = 2'b00; A1 = 3'd1; A2 = 3'd3; mode = 1'b0; ALU_control = 3'b001;
    cycle();
    n_checks++;
    if (ALU_out !== 8'h02) begin
      n_fails++;
      $display("[TB] FAIL dp_sub: ALU_out=%h, expected 02", ALU_out);
    end
    ResultSrc = 2'b00; RegWrite = 1'b1; A3 = 3'd2;
    cycle();
    RegWrite = 1'b0; A1 = 3'd2;
    #1;
    n_checks++;
    if (RD1 !== 8'h02) begin
      n_fails++;
      $display("[TB] FAIL dp_r2: RD1=%h, expected 02", RD1);
    end
    idle();
  endtask

  task automatic test_store_load();
    idle();
    A1 = 3'd1; imm = 8'h04; ALUSrcB = 2'b01; ALU_control = 3'b000;
    cycle();
    n_checks++;
    if (ALU_out !== 8'h09) begin
      n_fails++;
      $display("[TB] FAIL sl_addr: ALU_out=%h, expected 09", ALU_out);
    end
    MemWrite = 1'b1; A2 = 3'd3;
    cycle();
    MemWrite = 1'b0;
    n_checks++;
    if (DR_out !== 8'h00) begin
      n_fails++;
      $display("[TB] FAIL sl_old_value: DR_out=%h, expected 00", DR_out);
    end
    #1;
    n_checks++;
    if (memory_out !== 8'h03) begin
      n_fails++;
      $display("[TB] FAIL sl_mem9: memory_out=%h, expected 03", memory_out);
    end
    cycle();
    n_checks++;
    if (DR_out !== 8'h03) begin
      n_fails++;
      $display("[TB] FAIL sl_dr: DR_out=%h, expected 03", DR_out);
    end
    ResultSrc = 2'b01; RegWrite = 1'b1; A3 = 3'd4;
    cycle();
    RegWrite = 1'b0; A1 = 3'd4;
    #1;
    n_checks++;
    if (RD1 !== 8'h03) begin
      n_fails++;
      $display("[TB] FAIL sl_r4: RD1=%h, expected 03", RD1);
    end
    idle();
  endtask

  task automatic test_shift();
    logic [2:0] ops [3];
    logic [7:0] exp [3];
    ops[0] = 3'b011; exp[0] = 8'h03;
    ops[1] = 3'b010; exp[1] = 8'hC0;
    ops[2] = 3'b001; exp[2] = 8'h40;
    idle();
    load_reg(3'd5, 8'h81);
    A1 = 3'd5; mode = 1'b1; ALUSrcA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ALU_control = ops[i];
      cycle();
      n_checks++;
      if (ALU_out !== exp[i]) begin
        n_fails++;
        $display("[TB] FAIL shift_op%0d: ALU_out=%h, expected %h", ops[i], ALU_out, exp[i]);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    PCWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    repeat (2) cycle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (PC !== 8'h00 || ALU_out !== 8'h00 || DR_out !== 8'h00) begin
      n_fails++;
      $display("[TB] FAIL midreset_async: PC=%h ALU_out=%h DR_out=%h, expected 00", PC, ALU_out, DR_out);
    end
    reset_model();
    RegWrite = 1'b1; A3 = 3'd1; ResultSrc = 2'b11; imm = 8'h77;
    @(posedge clk);
    @(negedge clk);
    A1 = 3'd1;
    #1;
    n_checks++;
    if (RD1 !== 8'h00 || PC !== 8'h00) begin
      n_fails++;
      $display("[TB] FAIL midreset_blocked: RD1=%h PC=%h, expected 00/00", RD1, PC);
    end
    idle();
    rst_n = 1'b1;
    ALUSrcB = 2'b01; imm = 8'h09;
    cycle();
    n_checks++;
    if (int'(memory_out) !== m_mem[9] || memory_out !== 8'h03) begin
      n_fails++;
      $display("[TB] FAIL midreset_mem_kept: memory_out=%h, expected 03", memory_out);
    end
    idle();
  endtask

  task automatic test_r0();
    int expv;
    idle();
    load_reg(3'd0, 8'h55);
    A1 = 3'd0;
    #1;
`ifdef VERI_DATAPATH_R0_ZERO_EN
    expv = 0;
`else
    expv = 'h55;
`endif
    n_checks++;
    if (int'(RD1) !== expv) begin
      n_fails++;
      $display("[TB] FAIL r0_read: RD1=%h, expected %h", RD1, expv);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      mode = 1'($urandom); ALUSrcA = 1'($urandom); ALUSrcB = 2'($urandom);
      ALU_control = 3'($urandom); ResultSrc = 2'($urandom);
      MemWrite = 1'($urandom); RegWrite = 1'($urandom); PCWrite = 1'($urandom);
      A1 = 3'($urandom); A2 = 3'($urandom); A3 = 3'($urandom); imm = 8'($urandom);
      #1;
      n_checks++;
      if (int'(RD1) !== model_rd(int'(A1)) || int'(RD2) !== model_rd(int'(A2)) ||
          int'(SrcA) !== m_srca() || int'(SrcB) !== m_srcb() ||
          int'(result) !== m_result() || int'(memory_out) !== m_mem[m_alu_out]) begin
        n_fails++;
        $display("[TB] FAIL rand_comb[%0d]: RD1=%h RD2=%h SrcA=%h SrcB=%h result=%h mem=%h, expected %h %h %h %h %h %h",
                 n, RD1, RD2, SrcA, SrcB, result, memory_out, model_rd(int'(A1)), model_rd(int'(A2)),
                 m_srca(), m_srcb(), m_result(), m_mem[m_alu_out]);
      end
      cycle();
      n_checks++;
      if (int'(PC) !== m_pc || int'(ALU_out) !== m_alu_out || int'(DR_out) !== m_dr) begin
        n_fails++;
        $display("[TB] FAIL rand_seq[%0d]: PC=%h ALU_out=%h DR_out=%h, expected %h %h %h",
                 n, PC, ALU_out, DR_out, m_pc, m_alu_out, m_dr);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_proc();
    test_store_load();
    test_shift();
    test_reset_mid();
    test_r0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
